// File: rtl/vio_route_ctrl_pkg.sv
// Shared constants and types for the vFPGA per-region route controller.
package lynxTypes;

   localparam int VIO_ROUTE_BITS = 14;
   localparam int N_REGIONS      = 5;

   typedef logic [VIO_ROUTE_BITS-1:0] vio_route_t;

   typedef enum logic [1:0] {UNCFG, IDLE, PKT} vio_route_state_t;

   // Region index width; a single region still needs a 1-bit select.
   function automatic int unsigned vio_region_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vio_route_ctrl_if.sv
// Config port and user-stream/switch handshake bundle for vio_route_ctrl.
interface vio_route_ctrl_if
   import lynxTypes::*;
#(
   parameter int N_ID = N_REGIONS
);
   localparam int RW = vio_region_bits(N_ID);

   logic                  cfg_valid;
   logic                  cfg_ready;
   logic [RW-1:0]         cfg_region;
   vio_route_t            cfg_route;
   logic                  cfg_err;
   logic [N_ID-1:0][13:0] route_out;
   logic [N_ID-1:0]       cfg_pending;
   logic [N_ID-1:0]       cfg_active;
   logic [N_ID-1:0]       us_tvalid;
   logic [N_ID-1:0]       us_tlast;
   logic [N_ID-1:0]       us_tready;
   logic [N_ID-1:0]       sw_tvalid;
   logic [N_ID-1:0]       sw_tready;

   modport slave (
      input  cfg_valid, cfg_region, cfg_route, us_tvalid, us_tlast, sw_tready,
      output cfg_ready, cfg_err, route_out, cfg_pending, cfg_active, us_tready, sw_tvalid
   );

   modport master (
      output cfg_valid, cfg_region, cfg_route, us_tvalid, us_tlast, sw_tready,
      input  cfg_ready, cfg_err, route_out, cfg_pending, cfg_active, us_tready, sw_tvalid
   );

endinterface

// File: rtl/vio_route_ctrl_slot.sv
// One region's route slot: UNCFG/IDLE/PKT FSM, pending update, handshake gate.
// Optional per-region packet counter when VIO_ROUTE_STATS_EN is defined.
module vio_route_slot
   import lynxTypes::*;
#(
   parameter vio_route_t RST_ROUTE = '0
)(
   input  logic       aclk,
   input  logic       aresetn,
   input  logic       wr,
   input  vio_route_t wr_route,
   input  logic       us_tvalid,
   input  logic       us_tlast,
   input  logic       sw_tready,
   output logic       us_tready,
   output logic       sw_tvalid,
   output vio_route_t route,
   output logic       pend,
   output logic       active
`ifdef VIO_ROUTE_STATS_EN
   ,
   input  logic        stat_clr,
   output logic [31:0] stat_pkt_cnt
`endif
);

   vio_route_state_t state_q, state_d;
   logic             pend_q, pend_d;
   vio_route_t       pend_route_q, pend_route_d;
   vio_route_t       route_q, route_d;
   logic             gate_open;
   logic             fwd;
   logic             apply;
`ifdef VIO_ROUTE_STATS_EN
   logic [31:0]      cnt_q, cnt_d;
`endif

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= UNCFG;
         pend_q       <= 1'b0;
         pend_route_q <= RST_ROUTE;
         route_q      <= RST_ROUTE;
`ifdef VIO_ROUTE_STATS_EN
         cnt_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         pend_route_q <= pend_route_d;
         route_q      <= route_d;
`ifdef VIO_ROUTE_STATS_EN
         cnt_q        <= cnt_d;
`endif
      end
   end

   always_comb begin
      fwd          = sw_tvalid & sw_tready;
      apply        = pend_q & (state_q != PKT);
      state_d      = state_q;
      pend_d       = pend_q;
      pend_route_d = pend_route_q;
      route_d      = route_q;
      if (apply) begin
         state_d = IDLE;
         route_d = pend_route_q;
         pend_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE:    if (fwd && !us_tlast) state_d = PKT;
            PKT:     if (fwd &&  us_tlast) state_d = IDLE;
            default: state_d = state_q;
         endcase
      end
      // Writes are only accepted while pend is clear, so they never meet an apply.
      if (wr) begin
         pend_d       = 1'b1;
         pend_route_d = wr_route;
      end
`ifdef VIO_ROUTE_STATS_EN
      cnt_d = cnt_q;
      if (stat_clr)              cnt_d = '0;
      else if (fwd && us_tlast)  cnt_d = cnt_q + 32'd1;
`endif
   end

   always_comb begin
      gate_open = (state_q == PKT) | ((state_q == IDLE) & ~pend_q);
      sw_tvalid = gate_open & us_tvalid;
      us_tready = gate_open & sw_tready;
      route     = route_q;
      pend      = pend_q;
      active    = (state_q != UNCFG);
`ifdef VIO_ROUTE_STATS_EN
      stat_pkt_cnt = cnt_q;
`endif
   end

endmodule

// File: rtl/vio_route_ctrl.sv
// Per-region route controller: cfg decode, cfg_ready mux and sticky cfg_err;
// per-region state lives in vio_route_slot. Optional stats: VIO_ROUTE_STATS_EN.
module vio_route_ctrl
   import lynxTypes::*;
#(
   parameter int         N_ID      = N_REGIONS,
   parameter vio_route_t RST_ROUTE = '0
)(
   input logic            aclk,
   input logic            aresetn,
   vio_route_ctrl_if.slave io
`ifdef VIO_ROUTE_STATS_EN
   ,
   input  logic                  stat_clr,
   output logic [N_ID-1:0][31:0] stat_pkt_cnt
`endif
);

   localparam int          RW     = vio_region_bits(N_ID);
   localparam logic [RW:0] N_ID_W = (RW+1)'(N_ID);

   logic            in_range;
   logic            sel_pend;
   logic            accept;
   logic            cfg_err_q, cfg_err_d;
   logic [N_ID-1:0] wr;
   logic [N_ID-1:0] pend;

   always_comb begin
      in_range = {1'b0, io.cfg_region} < N_ID_W;
      sel_pend = 1'b0;
      for (int unsigned i = 0; i < N_ID; i++) begin
         if (io.cfg_region == RW'(i)) sel_pend = pend[i];
      end
      // Out-of-range writes are always taken so a bad master cannot stall the port.
      io.cfg_ready = in_range ? ~sel_pend : 1'b1;
      accept       = io.cfg_valid & io.cfg_ready;
      wr           = '0;
      for (int unsigned i = 0; i < N_ID; i++) begin
         wr[i] = accept & in_range & (io.cfg_region == RW'(i));
      end
      cfg_err_d = cfg_err_q | (accept & ~in_range);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) cfg_err_q <= 1'b0;
      else          cfg_err_q <= cfg_err_d;
   end

   assign io.cfg_err     = cfg_err_q;
   assign io.cfg_pending = pend;

   for (genvar g = 0; g < N_ID; g++) begin : g_slot
      vio_route_slot #(.RST_ROUTE(RST_ROUTE)) u_slot (
         .aclk         (aclk),
         .aresetn      (aresetn),
         .wr           (wr[g]),
         .wr_route     (io.cfg_route),
         .us_tvalid    (io.us_tvalid[g]),
         .us_tlast     (io.us_tlast[g]),
         .sw_tready    (io.sw_tready[g]),
         .us_tready    (io.us_tready[g]),
         .sw_tvalid    (io.sw_tvalid[g]),
         .route        (io.route_out[g]),
         .pend         (pend[g]),
         .active       (io.cfg_active[g])
`ifdef VIO_ROUTE_STATS_EN
         ,
         .stat_clr     (stat_clr),
         .stat_pkt_cnt (stat_pkt_cnt[g])
`endif
      );
   end

endmodule

// File: doc/vio_route_ctrl.md
# vio_route_ctrl

Per-region route controller for the vFPGA stream switch. Holds the 14-bit TDEST route word each region presents to the switch. Accepts route updates from a config port and applies each update only at a packet boundary, so a route never changes under a packet in flight. Sits between the user-logic stream valid/ready wires and the switch, gating handshakes while a region is unconfigured or an update is being applied.

## Interface
- N_ID, default N_REGIONS: number of regions.
- RST_ROUTE, default 14'h0: route value loaded into every slot at reset.
- aclk  in  1: clock.
- aresetn  in  1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- cfg_valid  in  1: route write request.
- cfg_ready  out  1: write accepted when high together with cfg_valid.
- cfg_region  in  $clog2(N_ID): target region.
- cfg_route  in  14: new route word.
- cfg_err  out  1: sticky; set by an accepted write with cfg_region >= N_ID; cleared only by reset.
- route_out  out  [N_ID][14]: routes driven to the switch s_axis_tdest for the user-logic streams.
- cfg_pending  out  N_ID: update pending per region.
- cfg_active  out  N_ID: region configured (left UNCFG).
- us_tvalid  in  N_ID: user-logic stream tvalid.
- us_tlast  in  N_ID: user-logic stream tlast.
- us_tready  out  N_ID: gated tready to user logic.
- sw_tvalid  out  N_ID: gated tvalid to the switch.
- sw_tready  in  N_ID: switch tready.

## Operation
- Each region has a slot FSM with states UNCFG, IDLE, PKT. Each slot also holds a pend flag, a pend_route register and a route register.
- A beat is fwd[i] = sw_tvalid[i] & sw_tready[i].
- Gate:
  - In UNCFG, or in IDLE with pend=1: sw_tvalid[i]=0 and us_tready[i]=0.
  - Otherwise: sw_tvalid=us_tvalid and us_tready=sw_tready.
- Transitions:
  - UNCFG→IDLE when a pending update is applied.
  - IDLE→PKT on fwd & !tlast.
  - IDLE stays IDLE on fwd & tlast (single-beat packet).
  - PKT→IDLE on fwd & tlast.
- Config:
  - cfg_ready = !pend[cfg_region] for in-range regions; always 1 for out-of-range regions.
  - An accepted in-range write sets pend and pend_route.
  - An accepted out-of-range write is dropped and sets cfg_err.
- Apply: when pend=1 and the state is IDLE or UNCFG, then next cycle route<=pend_route, pend<=0, and state becomes IDLE.
- A write arriving in the same cycle a first beat transfers: that beat and its packet use the old route; the update is applied after that packet's tlast.
- Writes to different regions are independent. Only one write per cycle.
- Reset, including mid-packet: all slots go to UNCFG, route=RST_ROUTE, pend=0, cfg_err=0. The in-flight packet is truncated; recovery is upstream's responsibility.

## Timing
- Reset values:
  - route_out = RST_ROUTE for all regions.
  - cfg_pending=0, cfg_active=0, cfg_err=0.
  - sw_tvalid=0, us_tready=0.
  - cfg_ready=1.
- Update from IDLE/UNCFG: write accepted at cycle t → pend=1 and gate closed at t+1 → route_out updated, pend=0 and gate open at t+2.
- Update during PKT: tlast beat at cycle tl → IDLE with gate closed at tl+1 → new route and gate open at tl+2.
- route_out is registered and changes only on an apply cycle. It is constant from the first beat to the tlast beat of every packet.
- Gating is combinational. There is no added latency on the valid/ready path.
- cfg_ready is combinational from cfg_region and pend.

## Configuration
- VIO_ROUTE_STATS_EN defined:
  - Adds output stat_pkt_cnt [N_ID][32], incrementing on every fwd & tlast.
  - Wraps modulo 2^32. Reset value 0.
  - Adds input stat_clr (1), which zeroes all counters the next cycle. stat_clr wins over a simultaneous increment.
- Not defined: these ports and the counters are absent. All other behaviour is identical.

## Structure
- Constants and types go in lynxTypes:
  - VIO_ROUTE_BITS=14.
  - Slot state enum vio_route_state_t {UNCFG, IDLE, PKT}.
- Sub-module vio_route_slot: one per region, instantiated N_ID times.
  - Contains the FSM, pend, pend_route, route, the gate and the optional counter.
- The top level holds the cfg decode, cfg_ready mux and cfg_err only.

## Test plan
- Reset with us_tvalid=1 on region 0 → sw_tvalid[0]=0, us_tready[0]=0. Write 14'h0A5C to region 0 → route_out[0]=14'h0A5C at t+2; sw_tvalid follows us_tvalid from t+2.
- Region 1 configured and mid-packet, beat 2 of 4; write 14'h1234 → route_out[1] unchanged through the tlast beat; gate low one cycle; route 14'h1234 two cycles after tlast.
- Second write to region 1 while pend[1]=1 → cfg_ready=0. Same-cycle write to region 2 → accepted.
- Write with cfg_region=N_ID → cfg_ready=1, no route changes, cfg_err=1 and held.
- Back-to-back single-beat packets on region 3 with continuous us_tvalid, plus one write → exactly one gated cycle; no beat is sent on the old route after the apply cycle.
- VIO_ROUTE_STATS_EN: 5 packets on region 0 → stat_pkt_cnt[0]=5. stat_clr asserted together with a tlast beat → 0. Aresetn pulse mid-packet → all slots UNCFG, counters 0.
